// File: rtl/arm_dp_pkg.sv
// rtl/arm_dp_pkg.sv - shared ARM data-processing opcode, condition and flag constants
package arm_dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluation
// Ports: cond - condition field; nzcv - committed flags {N,Z,C,V}; pass - condition holds.
module cond_check
    import arm_dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[N_BIT];
    assign z = nzcv[Z_BIT];
    assign c = nzcv[C_BIT];
    assign v = nzcv[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_alu_stage.sv
// rtl/dp_alu_stage.sv - ARM data-processing execute stage with NZCV ownership
// Ports: in_* upstream beat (valid/ready), out_* registered writeback beat (valid/ready),
// cpsr_flags committed {N,Z,C,V}, c_flag committed carry for barrel_shifter.
// DP_ALU_PERF_CNT_EN adds perf_exec/perf_skip executed/skipped beat counters.
module dp_alu_stage
    import arm_dp_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic              in_s,
    input  logic [3:0]        in_cond,
    input  logic [DW-1:0]     in_rn,
    input  logic [DW-1:0]     in_shifter_operand,
    input  logic              in_shifter_carry,
    input  logic [RIDX_W-1:0] in_rd_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_result,
    output logic [RIDX_W-1:0] out_rd_idx,
    output logic              out_wr_en,
    output logic [3:0]        cpsr_flags,
    output logic              c_flag
`ifdef DP_ALU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_exec,
    output logic [31:0]       perf_skip
`endif
);

    logic [3:0]    flags;
    logic [3:0]    next_flags;
    logic          cond_pass;
    logic          accept;
    logic          is_test;
    logic          is_arith;
    logic          carry_in;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] logic_res;
    logic [DW-1:0] alu_res;
    logic [DW:0]   sum;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign is_test    = (in_opcode[3:2] == 2'b10);
    assign cpsr_flags = flags;
    assign c_flag     = flags[C_BIT];

    cond_check u_cond_check (
        .cond (in_cond),
        .nzcv (flags),
        .pass (cond_pass)
    );

    // All arithmetic ops share one adder: subtraction is a + ~b + carry_in,
    // reverse forms swap the operands first.
    always_comb begin
        op_a     = in_rn;
        op_b     = in_shifter_operand;
        carry_in = 1'b0;
        is_arith = 1'b1;
        case (in_opcode)
            OP_ADD, OP_CMN: carry_in = 1'b0;
            OP_ADC: carry_in = flags[C_BIT];
            OP_SUB, OP_CMP: begin
                op_b     = ~in_shifter_operand;
                carry_in = 1'b1;
            end
            OP_SBC: begin
                op_b     = ~in_shifter_operand;
                carry_in = flags[C_BIT];
            end
            OP_RSB: begin
                op_a     = in_shifter_operand;
                op_b     = ~in_rn;
                carry_in = 1'b1;
            end
            OP_RSC: begin
                op_a     = in_shifter_operand;
                op_b     = ~in_rn;
                carry_in = flags[C_BIT];
            end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, carry_in};

    always_comb begin
        logic_res = '0;
        case (in_opcode)
            OP_AND, OP_TST: logic_res = in_rn & in_shifter_operand;
            OP_EOR, OP_TEQ: logic_res = in_rn ^ in_shifter_operand;
            OP_ORR:         logic_res = in_rn | in_shifter_operand;
            OP_MOV:         logic_res = in_shifter_operand;
            OP_BIC:         logic_res = in_rn & ~in_shifter_operand;
            OP_MVN:         logic_res = ~in_shifter_operand;
            default:        logic_res = '0;
        endcase
    end

    assign alu_res = is_arith ? sum[DW-1:0] : logic_res;

    // Overflow: adder inputs agree in sign but the result does not.
    always_comb begin
        next_flags        = flags;
        next_flags[N_BIT] = alu_res[DW-1];
        next_flags[Z_BIT] = (alu_res == '0);
        next_flags[C_BIT] = is_arith ? sum[DW] : in_shifter_carry;
        if (is_arith) begin
            next_flags[V_BIT] = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd_idx <= '0;
            out_wr_en  <= 1'b0;
            flags      <= 4'b0000;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_result <= cond_pass ? alu_res : '0;
                out_rd_idx <= in_rd_idx;
                out_wr_en  <= cond_pass && !is_test;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && cond_pass && (in_s || is_test)) begin
                flags <= next_flags;
            end
        end
    end

`ifdef DP_ALU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_exec <= '0;
            perf_skip <= '0;
        end else if (accept) begin
            if (cond_pass) begin
                perf_exec <= perf_exec + 32'd1;
            end else begin
                perf_skip <= perf_skip + 32'd1;
            end
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_dp_alu_stage.sv
// tb/tb_dp_alu_stage.sv - self-checking bench for dp_alu_stage
module tb_dp_alu_stage;
    import arm_dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic        in_s;
    logic [3:0]  in_cond;
    logic [31:0] in_rn;
    logic [31:0] in_shifter_operand;
    logic        in_shifter_carry;
    logic [3:0]  in_rd_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd_idx;
    logic        out_wr_en;
    logic [3:0]  cpsr_flags;
    logic        c_flag;
`ifdef DP_ALU_PERF_CNT_EN
    logic [31:0] perf_exec;
    logic [31:0] perf_skip;
`endif

    always #5 clk = ~clk;

    dp_alu_stage #(.DW(32), .RIDX_W(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_opcode          (in_opcode),
        .in_s               (in_s),
        .in_cond            (in_cond),
        .in_rn              (in_rn),
        .in_shifter_operand (in_shifter_operand),
        .in_shifter_carry   (in_shifter_carry),
        .in_rd_idx          (in_rd_idx),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_result         (out_result),
        .out_rd_idx         (out_rd_idx),
        .out_wr_en          (out_wr_en),
        .cpsr_flags         (cpsr_flags),
        .c_flag             (c_flag)
`ifdef DP_ALU_PERF_CNT_EN
        ,
        .perf_exec          (perf_exec),
        .perf_skip          (perf_skip)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural meaning of each condition and opcode.
    function automatic bit model_cond(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cond == 4'hE) return 1'b1;
        if (cond == 4'hF) return 1'b0;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic void model_alu(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] opd,
                                      input logic cin, input logic sc, input logic vin,
                                      output logic [31:0] r, output logic c, output logic v);
        longint ur, uo, sr, so, uu, su, ci;
        bit arith, is_sub;
        ur = longint'(rn);
        uo = longint'(opd);
        sr = longint'($signed(rn));
        so = longint'($signed(opd));
        ci = cin ? 1 : 0;
        arith = 1'b1;
        is_sub = 1'b0;
        uu = 0;
        su = 0;
        case (op)
            OP_ADD, OP_CMN: begin uu = ur + uo;          su = sr + so;          end
            OP_ADC:         begin uu = ur + uo + ci;     su = sr + so + ci;     end
            OP_SUB, OP_CMP: begin uu = ur - uo;          su = sr - so;          is_sub = 1'b1; end
            OP_SBC:         begin uu = ur - uo - 1 + ci; su = sr - so - 1 + ci; is_sub = 1'b1; end
            OP_RSB:         begin uu = uo - ur;          su = so - sr;          is_sub = 1'b1; end
            OP_RSC:         begin uu = uo - ur - 1 + ci; su = so - sr - 1 + ci; is_sub = 1'b1; end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            r = uu[31:0];
            c = is_sub ? (uu >= 0) : (uu > 64'sh0FFFFFFFF);
            v = (su > 64'sd2147483647) || (su < -64'sd2147483648);
        end else begin
            case (op)
                OP_AND, OP_TST: r = rn & opd;
                OP_EOR, OP_TEQ: r = rn ^ opd;
                OP_ORR:         r = rn | opd;
                OP_MOV:         r = opd;
                OP_BIC:         r = rn & ~opd;
                default:        r = ~opd;
            endcase
            c = sc;
            v = vin;
        end
    endfunction

    bit          m_valid = 1'b0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_rd = '0;
    bit          m_wr = 1'b0;
    logic [3:0]  m_flags = '0;
    logic [31:0] m_exec = '0;
    logic [31:0] m_skip = '0;

    always @(posedge clk or negedge rst_n) begin
        bit acc, pass, is_test;
        logic [31:0] r;
        logic c, v;
        if (!rst_n) begin
            m_valid = 1'b0; m_result = '0; m_rd = '0; m_wr = 1'b0; m_flags = '0;
            m_exec = '0; m_skip = '0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                pass = model_cond(in_cond, m_flags);
                is_test = (in_opcode >= OP_TST) && (in_opcode <= OP_CMN);
                model_alu(in_opcode, in_rn, in_shifter_operand, m_flags[1], in_shifter_carry, m_flags[0], r, c, v);
                m_valid = 1'b1;
                m_result = pass ? r : 32'h0;
                m_wr = pass && !is_test;
                m_rd = in_rd_idx;
                if (pass && (in_s || is_test)) m_flags = {r[31], (r == 32'h0), c, v};
                if (pass) m_exec = m_exec + 1; else m_skip = m_skip + 1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || out_ready)});
        chk("cpsr_flags", {28'b0, cpsr_flags}, {28'b0, m_flags});
        chk("c_flag", {31'b0, c_flag}, {31'b0, m_flags[1]});
        if (m_valid) begin
            chk("out_result", out_result, m_result);
            chk("out_rd_idx", {28'b0, out_rd_idx}, {28'b0, m_rd});
            chk("out_wr_en", {31'b0, out_wr_en}, {31'b0, m_wr});
        end
`ifdef DP_ALU_PERF_CNT_EN
        chk("perf_exec", perf_exec, m_exec);
        chk("perf_skip", perf_skip, m_skip);
`endif
    end

    task automatic drive(input logic [3:0] op, input logic s, input logic [3:0] cond, input logic [31:0] rn,
                         input logic [31:0] opd, input logic carry, input logic [3:0] rd);
        in_opcode = op; in_s = s; in_cond = cond; in_rn = rn;
        in_shifter_operand = opd; in_shifter_carry = carry; in_rd_idx = rd;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic s, input logic [3:0] cond, input logic [31:0] rn,
                        input logic [31:0] opd, input logic carry, input logic [3:0] rd);
        drive(op, s, cond, rn, opd, carry, rd);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rnv [3] = '{32'h80000000, 32'h12345678, 32'h00000000};
    logic [31:0] opv [3] = '{32'h80000000, 32'hFEDCBA98, 32'h00000000};
    logic        cv  [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] ca  [5] = '{32'd5, 32'd3, 32'h80000000, 32'd7, 32'h7FFFFFFF};
    logic [31:0] cb  [5] = '{32'd5, 32'd7, 32'd1, 32'd3, 32'hFFFFFFFF};

    initial begin
        logic [31:0] pr, res_a, res_b;
        logic pc, pv;
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_opcode = '0; in_s = 1'b0; in_cond = '0; in_rn = '0;
        in_shifter_operand = '0; in_shifter_carry = 1'b0; in_rd_idx = '0;

        chk("pin_cond_ge", {31'b0, model_cond(COND_GE, 4'b1001)}, 32'd1);
        chk("pin_cond_hi", {31'b0, model_cond(COND_HI, 4'b0110)}, 32'd0);
        model_alu(OP_SBC, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0, pr, pc, pv);
        chk("pin_sbc", {pr[30:0], pc}, {31'd1, 1'b1});
        model_alu(OP_RSC, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0, pr, pc, pv);
        chk("pin_rsc", {pr[30:0], pc}, {31'd2, 1'b1});
        model_alu(OP_SUB, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, pr, pc, pv);
        chk("pin_sub_borrow", pr, 32'hFFFFFFFF);
        chk("pin_sub_cv", {30'b0, pc, pv}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd_idx", {28'b0, out_rd_idx}, 32'd0);
        chk("rst_out_wr_en", {31'b0, out_wr_en}, 32'd0);
        chk("rst_flags", {28'b0, cpsr_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(OP_ADD, 1'b1, COND_AL, 32'h7FFFFFFF, 32'd1, 1'b0, 4'd3);
        chk("adds_result", out_result, 32'h80000000);
        chk("adds_wr_en", {31'b0, out_wr_en}, 32'd1);
        chk("adds_flags", {28'b0, cpsr_flags}, 32'h9);

        send(OP_SUB, 1'b1, COND_AL, 32'd5, 32'd5, 1'b0, 4'd4);
        chk("subs_result", out_result, 32'd0);
        chk("subs_flags", {28'b0, cpsr_flags}, 32'h6);
        send(OP_MOV, 1'b0, COND_EQ, 32'd0, 32'hA5, 1'b0, 4'd5);
        chk("moveq_result", out_result, 32'hA5);
        chk("moveq_wr_en", {31'b0, out_wr_en}, 32'd1);

        send(OP_CMP, 1'b0, COND_AL, 32'd3, 32'd7, 1'b0, 4'd6);
        chk("cmp_wr_en", {31'b0, out_wr_en}, 32'd0);
        chk("cmp_flags", {28'b0, cpsr_flags}, 32'h8);
        send(OP_ADD, 1'b0, COND_NE, 32'd1, 32'd2, 1'b0, 4'd7);
        chk("addne_result", out_result, 32'd3);
        chk("addne_wr_en", {31'b0, out_wr_en}, 32'd1);
        send(OP_ADD, 1'b1, COND_EQ, 32'd1, 32'd2, 1'b0, 4'd8);
        chk("addeq_wr_en", {31'b0, out_wr_en}, 32'd0);
        chk("addeq_result", out_result, 32'd0);
        chk("addeq_flags", {28'b0, cpsr_flags}, 32'h8);

        send(OP_ADD, 1'b1, COND_AL, 32'h7FFFFFFF, 32'd1, 1'b0, 4'd1);
        send(OP_AND, 1'b1, COND_AL, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 4'd9);
        chk("ands_result", out_result, 32'd0);
        chk("ands_flags", {28'b0, cpsr_flags}, 32'h7);

        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 3; k++) begin
                send(op[3:0], 1'b1, COND_AL, rnv[k], opv[k], cv[k], op[3:0]);
            end
        end

        for (int cc = 0; cc < 16; cc++) begin
            for (int k = 0; k < 5; k++) begin
                send(OP_CMP, 1'b0, COND_AL, ca[k], cb[k], 1'b0, 4'd0);
                send(OP_ADD, 1'b0, cc[3:0], 32'(cc), 32'd1, 1'b0, 4'd1);
            end
        end

        // Backpressure: first beat held, second waits, then drain and accept together.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(OP_ADD, 1'b0, COND_AL, 32'd10, 32'd20, 1'b0, 4'd2);
        res_a = 32'd30;
        res_b = 32'h11;
        @(posedge clk);
        #1;
        drive(OP_EOR, 1'b0, COND_AL, 32'h10, 32'h01, 1'b0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_result", out_result, res_a);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("drain_next_result", out_result, res_b);
        chk("drain_next_valid", {31'b0, out_valid}, 32'd1);
        chk("drain_next_rd", {28'b0, out_rd_idx}, 32'd3);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(OP_ADD, 1'b1, COND_AL, 32'd0, 32'd0, 1'b0, 4'd1);
        for (int i = 0; i < 2; i++) send(OP_ADD, 1'b1, COND_NV, 32'd1, 32'd1, 1'b0, 4'd1);
`ifdef DP_ALU_PERF_CNT_EN
        chk("perf_exec_4", perf_exec, 32'd4);
        chk("perf_skip_2", perf_skip, 32'd2);
`endif
        chk("pre_reset_flags", {28'b0, cpsr_flags}, 32'h4);
        out_ready = 1'b0;
        drive(OP_ADD, 1'b1, COND_AL, 32'd1, 32'd1, 1'b0, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_pending_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_flags", {28'b0, cpsr_flags}, 32'd0);
        chk("midrst_result", out_result, 32'd0);
`ifdef DP_ALU_PERF_CNT_EN
        chk("midrst_perf_exec", perf_exec, 32'd0);
        chk("midrst_perf_skip", perf_skip, 32'd0);
`endif
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_alu_stage.md
Name: dp_alu_stage

Overview:
Execute stage for ARM data-processing instructions, directly downstream of barrel_shifter. Consumes Rn plus the shifter's operand and carry, evaluates the condition field against the committed NZCV flags, computes the ALU result and new flags, and presents a registered writeback beat. Owns the NZCV register and drives barrel_shifter.c_flag.

Parameters:
DW, 32, datapath width; only 32 is supported.
RIDX_W, 4, destination register index width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat.
in_opcode  in  4  ARM DP opcode, bits [24:21].
in_s  in  1  S bit; update flags.
in_cond  in  4  condition field, bits [31:28].
in_rn  in  32  first operand.
in_shifter_operand  in  32  from barrel_shifter.shifter_operand.
in_shifter_carry  in  1  bit 0 of barrel_shifter.shifter_carry_out.
in_rd_idx  in  4  destination register index.
out_valid  out  1  writeback beat valid.
out_ready  in  1  downstream accepts the beat.
out_result  out  32  ALU result.
out_rd_idx  out  4  destination index.
out_wr_en  out  1  write Rd: condition passed and the opcode is not TST/TEQ/CMP/CMN.
cpsr_flags  out  4  committed {N,Z,C,V}.
c_flag  out  1  cpsr_flags[1]; wired to barrel_shifter.c_flag.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_result=0, out_rd_idx=0, out_wr_en=0, cpsr_flags=4'b0000.
- Handshake: in_ready = !out_valid || out_ready. A beat is accepted when in_valid && in_ready. Its result is registered and appears with out_valid=1 on the next cycle (latency 1). Output is held stable while out_valid && !out_ready. No combinational path from in_valid to out_*.
- Condition: evaluated on the committed flags at accept. EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE follow standard ARM semantics. AL (1110) passes. 1111 fails.
- Failed condition: the beat still produces an output beat with out_wr_en=0 and out_result=0. Flags are unchanged.
- Arithmetic: 33-bit add. SUB=Rn+~op+1, RSB=op+~Rn+1, ADC=Rn+op+C, SBC=Rn+~op+C, RSC=op+~Rn+C. CMP behaves as SUB and CMN as ADD, with no write.
  - C = carry-out bit 32.
  - V = signed overflow from the operand/result MSBs.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = in_shifter_carry; V unchanged. MOV/MVN ignore Rn.
- N = result[31], Z = (result==0). This applies to all opcodes.
- Flag update: flags are written at the accept edge when the condition passes and either in_s=1 or the opcode is TST/TEQ/CMP/CMN (these always set flags). The next accepted beat evaluates against the updated flags (back-to-back dependent CMP then BEQ-style beats are correct). c_flag reflects the flags register, so a shifter operand formed in the same cycle as a flag-setting accept sees the old C. The decode unit must stall for that hazard.
- Simultaneous accept and drain in one cycle: the output register is replaced without a bubble.
- Reset mid-stall drops the pending beat and clears the flags.

Optional Feature:
Macro DP_ALU_PERF_CNT_EN.
- Defined: adds outputs perf_exec[31:0] and perf_skip[31:0]. Each accepted beat increments perf_exec if its condition passed, else perf_skip. Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package arm_dp_pkg holds:
  - opcode constants OP_AND..OP_MVN;
  - condition constants COND_EQ..COND_NV;
  - flag bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- arm_defines.vh keeps the barrel_sel codes.
- One sub-module: cond_check, combinational, taking (cond[3:0], nzcv[3:0]) and returning pass.
- ALU datapath and pipeline register stay in dp_alu_stage.

Test Plan:
- Reset, then ADD S=1 with Rn=32'h7FFFFFFF, op=1, AL: next cycle result=32'h80000000, wr_en=1; flags NZCV=1001.
- SUBS Rn=5, op=5, then MOVEQ op=32'hA5 back-to-back: SUBS gives result 0, Z=1, C=1. MOVEQ passes with result 32'hA5.
- CMP Rn=3, op=7, then ADDNE and ADDEQ: CMP has wr_en=0 and flags N=1 C=0. ADDNE executes; ADDEQ gives wr_en=0, result=0, flags unchanged.
- Hold out_ready=0 for 3 cycles with in_valid=1: in_ready=0, output is stable and the second beat is not accepted. When out_ready=1, the beat drains and the next is accepted the same cycle.
- ANDS Rn=32'hFFFF0000, op=32'h0000FFFF, carry=1, prior V=1: result 0, NZCV=0111.
- With DP_ALU_PERF_CNT_EN, send 4 AL beats and 2 failing beats, plus one rst_n pulse mid-stall: counters read 4 and 2, and after reset read 0/0 with out_valid=0.
